// File: rtl/dmem_access_master.sv
// Load/store master for a single-port word memory: byte/half/word access with
// read-modify-write for sub-word stores. Latency 2 (load, word store), 3 (sub-word store), 1 (error); req_ready low while busy.
module dmem_access_master #(
  parameter int ADDR_W    = 18,
  parameter int MEM_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [2:0] {
    IDLE, LD, ST, RMW_RD, RMW_WR, RESP, ERR
  } state_t;

  localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_WORDS);

  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic [1:0]          off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_error_q, resp_error_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [31:0]         mem_write_data_q, mem_write_data_d;
  logic                mem_write_q, mem_write_d;
  logic                mem_read_q, mem_read_d;

  logic [ADDR_W-1:0]   req_idx;
  logic                req_err;
  logic                unused_addr_hi;

  assign req_idx        = req_addr[ADDR_W+1:2];
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = (req_addr[1:0] != 2'b00);
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if ({1'b0, req_idx} >= MEM_LIM) req_err = 1'b1;
  end

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] w, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) begin
      case (off)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (off[1]) begin
      r[31:16] = wd[15:0];
    end else begin
      r[15:0] = wd[15:0];
    end
    return r;
  endfunction

  always_comb begin
    state_d          = state_q;
    off_d            = off_q;
    size_d           = size_q;
    signed_d         = signed_q;
    wdata_d          = wdata_q;
    resp_rdata_d     = resp_rdata_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    resp_valid_d     = 1'b0;
    resp_error_d     = 1'b0;
    mem_write_d      = 1'b0;
    mem_read_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          off_d         = req_addr[1:0];
          size_d        = req_size;
          signed_d      = req_signed;
          wdata_d       = req_wdata;
          mem_address_d = req_idx;
          if (req_err) begin
            state_d      = ERR;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = 32'd0;
          end else if (!req_write) begin
            state_d    = LD;
            mem_read_d = 1'b1;
          end else if (req_size == 2'b10) begin
            state_d          = ST;
            mem_write_d      = 1'b1;
            mem_write_data_d = req_wdata;
          end else begin
            state_d    = RMW_RD;
            mem_read_d = 1'b1;
          end
        end
      end
      LD: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = fmt_load(mem_read_data, size_q, off_q, signed_q);
      end
      ST: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'd0;
      end
      RMW_RD: begin
        // The old word is merged on the fly and held as the write data.
        state_d          = RMW_WR;
        mem_write_d      = 1'b1;
        mem_write_data_d = merge_store(mem_read_data, wdata_q, size_q, off_q);
      end
      RMW_WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'd0;
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      req_ready_q      <= 1'b0;
      off_q            <= 2'd0;
      size_q           <= 2'd0;
      signed_q         <= 1'b0;
      wdata_q          <= 32'd0;
      resp_valid_q     <= 1'b0;
      resp_error_q     <= 1'b0;
      resp_rdata_q     <= 32'd0;
      mem_address_q    <= '0;
      mem_write_data_q <= 32'd0;
      mem_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      req_ready_q      <= req_ready_d;
      off_q            <= off_d;
      size_q           <= size_d;
      signed_q         <= signed_d;
      wdata_q          <= wdata_d;
      resp_valid_q     <= resp_valid_d;
      resp_error_q     <= resp_error_d;
      resp_rdata_q     <= resp_rdata_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_write_q      <= mem_write_d;
      mem_read_q       <= mem_read_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_error     = resp_error_q;
  assign resp_rdata     = resp_rdata_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_write      = mem_write_q;
  assign mem_read       = mem_read_q;

endmodule

// File: tb/tb_dmem_access_master.sv
// Bench for dmem_access_master: directed cases plus random traffic against a
// word-array reference model of the memory and the load/store rules.
module tb_dmem_access_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [17:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  logic [31:0] dut_mem [256];
  logic [31:0] ref_mem [256];

  int n_checks = 0;
  int n_errors = 0;

  dmem_access_master #(.ADDR_W(18), .MEM_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_write && mem_address < 18'd256) dut_mem[mem_address[7:0]] <= mem_write_data;

  assign mem_read_data = (mem_read && mem_address < 18'd256) ? dut_mem[mem_address[7:0]]
                                                              : 32'h0BAD_F00D;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic sg);
    logic [31:0] v;
    v = w >> (8 * off);
    if (sz == 2'd0) begin
      v = v & 32'hFF;
      if (sg && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'hFFFF;
      if (sg && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Entered and left at a negative edge.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    int          n, cyc, wr_n, rd_n, both;
    int          idx, lat, exp_wr, exp_rd;
    logic [1:0]  off;
    logic        err;
    logic [31:0] exp_rdata, w, mask;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("ready_wait", req_ready, 1);
    req_valid = 1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;

    idx = int'(a[19:2]);
    off = a[1:0];
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && off != 2'd0) || idx >= 256;
    exp_rdata = 32'd0;
    if (err) begin lat = 1; exp_wr = 0; exp_rd = 0; end
    else if (!wr) begin
      lat = 2; exp_wr = 0; exp_rd = 1;
      exp_rdata = ref_load(ref_mem[idx], sz, off, sg);
    end else if (sz == 2'd2) begin
      lat = 2; exp_wr = 1; exp_rd = 0;
      ref_mem[idx] = wd;
    end else begin
      lat = 3; exp_wr = 1; exp_rd = 1;
      mask = (sz == 2'd0 ? 32'hFF : 32'hFFFF) << (8 * off);
      w = ref_mem[idx];
      ref_mem[idx] = (w & ~mask) | ((wd << (8 * off)) & mask);
    end

    @(posedge clk);
    #1;
    req_valid = 0;
    req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;

    cyc = 0; wr_n = 0; rd_n = 0; both = 0;
    while (cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (mem_write) wr_n++;
      if (mem_read) rd_n++;
      if (mem_write && mem_read) both = 1;
      if (cyc == 1 && !err) chk("mem_address", 32'(mem_address), idx);
      if (resp_valid) break;
    end
    chk("latency", cyc, lat);
    chk("resp_error", resp_error, err);
    chk("resp_rdata", resp_rdata, exp_rdata);
    chk("mem_writes", wr_n, exp_wr);
    chk("mem_reads", rd_n, exp_rd);
    chk("rd_wr_overlap", both, 0);
    if (idx < 256) chk("mem_word", dut_mem[idx], ref_mem[idx]);
    @(negedge clk);
    chk("resp_pulse", resp_valid, 0);
    chk("rdata_hold", resp_rdata, exp_rdata);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
  } req_t;

  initial begin
    req_t        q [3];
    logic [31:0] exp_q [3];
    int          ack, resp_n, wr_n;
    logic [31:0] w;

    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      dut_mem[i] = w;
      ref_mem[i] = w;
    end
    rst_n = 0; req_valid = 0; req_write = 0; req_size = 0; req_signed = 0;
    req_addr = 0; req_wdata = 0;
    #12;
    chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_ctrl", {mem_read, mem_write}, 0);
    chk("rst_mem_addr", 32'(mem_address), 0);
    @(negedge clk); rst_n = 1;
    chk("ready_after_release", req_ready, 0);
    @(negedge clk);
    chk("ready_one_cycle", req_ready, 1);

    do_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
    do_req(0, 2'd2, 0, 32'h10, 0);
    chk("lw_value", resp_rdata, 32'hDEADBEEF);
    do_req(1, 2'd2, 0, 32'h10, 32'h11223344);
    do_req(1, 2'd0, 0, 32'h12, 32'h000000AA);
    chk("sb_word", dut_mem[4], 32'h11AA3344);
    do_req(0, 2'd0, 1, 32'h12, 0);
    chk("lb_signed", resp_rdata, 32'hFFFFFFAA);
    do_req(0, 2'd0, 0, 32'h12, 0);
    chk("lbu", resp_rdata, 32'h000000AA);
    do_req(0, 2'd1, 1, 32'h12, 0);
    chk("lh_signed", resp_rdata, 32'h000011AA);
    do_req(0, 2'd2, 0, 32'h13, 0);
    do_req(1, 2'd2, 0, 32'h400, 32'h12345678);
    do_req(0, 2'd3, 0, 32'h10, 0);
    do_req(1, 2'd1, 0, 32'h11, 32'hFFFF);

    // Reset while the sub-word store sits in its read phase.
    w = dut_mem[4];
    req_valid = 1; req_write = 1; req_size = 2'd1; req_signed = 0;
    req_addr = 32'h10; req_wdata = 32'hBEEF;
    @(posedge clk); #1; req_valid = 0;
    chk("rmw_rd_phase", mem_read, 1);
    rst_n = 0; #1;
    chk("rst_mid_ctrl", {resp_valid, resp_error, mem_read, mem_write}, 0);
    chk("rst_mid_rdata", resp_rdata, 0);
    chk("rst_mid_wdata", mem_write_data, 0);
    chk("rst_mid_addr", 32'(mem_address), 0);
    @(negedge clk); @(negedge clk); rst_n = 1;
    chk("rst_mid_word", dut_mem[4], w);
    @(negedge clk);
    chk("rst_mid_ready", req_ready, 1);

    // Three requests queued behind a continuously asserted req_valid.
    q[0] = '{wr: 1, sz: 2'd2, a: 32'h20, wd: 32'hCAFEF00D};
    q[1] = '{wr: 0, sz: 2'd2, a: 32'h20, wd: 32'h0};
    q[2] = '{wr: 1, sz: 2'd0, a: 32'h21, wd: 32'h55};
    exp_q[0] = 0; exp_q[1] = 32'hCAFEF00D; exp_q[2] = 0;
    ref_mem[8] = 32'hCAFE550D;
    ack = 0; resp_n = 0; wr_n = 0;
    req_valid = 1; req_signed = 0;
    req_write = q[0].wr; req_size = q[0].sz; req_addr = q[0].a; req_wdata = q[0].wd;
    for (int cyc = 0; cyc < 40 && resp_n < 3; cyc++) begin
      if (resp_valid) begin
        chk("b2b_rdata", resp_rdata, exp_q[resp_n]);
        chk("b2b_ready_busy", req_ready, 0);
        resp_n++;
      end
      if (mem_write) wr_n++;
      if (req_valid && req_ready) begin
        @(posedge clk); #1;
        ack++;
        if (ack < 3) begin
          req_write = q[ack].wr; req_size = q[ack].sz;
          req_addr = q[ack].a; req_wdata = q[ack].wd;
        end else req_valid = 0;
      end
      @(negedge clk);
    end
    chk("b2b_accepts", ack, 3);
    chk("b2b_responses", resp_n, 3);
    chk("b2b_writes", wr_n, 2);
    chk("b2b_word", dut_mem[8], ref_mem[8]);
    req_valid = 0;
    @(negedge clk);

    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      a = (t % 7 == 0) ? $urandom_range(1020, 1100) : $urandom_range(0, 1023);
      do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dmem_access_master.md
Name: dmem_access_master

Overview:
- Load/store master that drives the single-port, word-organised data memory on behalf of the processor datapath.
- Accepts byte, halfword and word load/store requests through a valid/ready handshake.
- Converts each byte address to a word index and performs read-modify-write for sub-word stores.
- Returns aligned and extended load data, or an error flag, through a one-cycle response strobe.

Parameters:
ADDR_W, 18, width of the memory word-address bus
MEM_WORDS, 256, number of implemented memory words; word indices at or above this value are errors

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  master idle, request accepted when req_valid && req_ready at posedge
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved
req_signed  input  1  sign-extend sub-word loads
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle completion strobe
resp_rdata  output  32  load result, 0 for stores and errors
resp_error  output  1  valid with resp_valid; misaligned, reserved size or out of range
mem_address  output  ADDR_W  memory word index
mem_write_data  output  32  memory write data
mem_write  output  1  memory write enable; memory writes at posedge
mem_read  output  1  memory read enable
mem_read_data  input  32  memory read data, combinational from mem_address while mem_read=1

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE immediately.
  - resp_valid, resp_error, mem_write and mem_read go to 0. resp_rdata, mem_address and mem_write_data go to 0.
  - req_ready goes to 1 one cycle after rst_n deasserts.
- Request capture: on accept, latch addr, wdata, size, signed and write. Later changes on the req_* inputs are ignored.
- req_ready is high only in IDLE, so only one request is outstanding at a time.
- Word index is req_addr[ADDR_W+1:2]. Byte offset is req_addr[1:0].
- Error conditions:
  - size 01 with addr[0]=1
  - size 10 with addr[1:0]≠0
  - size 11
  - word index ≥ MEM_WORDS
  - Any error goes to ERR and never touches memory: mem_read and mem_write stay 0.
- State machine: IDLE, LD, ST, RMW_RD, RMW_WR, RESP, ERR.
  - IDLE → ERR: accepted request hits an error condition.
  - IDLE → LD: accepted load.
  - IDLE → ST: accepted word store.
  - IDLE → RMW_RD: accepted byte or half store.
  - LD: mem_read=1. Sample mem_read_data at the edge, format it into resp_rdata, go to RESP.
  - ST: mem_write=1, mem_write_data = wdata, go to RESP.
  - RMW_RD: mem_read=1. Latch the old word, go to RMW_WR.
  - RMW_WR: mem_write=1 with the merged word, go to RESP.
    - Byte store: replace lane k = addr[1:0], bits [8k+7:8k], with wdata[7:0].
    - Half store: replace [15:0] (offset 0) or [31:16] (offset 2) with wdata[15:0].
  - RESP: resp_valid=1 for one cycle, resp_error=0. Return to IDLE.
  - ERR: resp_valid=1 and resp_error=1 for one cycle, resp_rdata=0. Return to IDLE.
- Latency, counted as cycles from the accept edge to the resp_valid cycle:
  - load: 2
  - word store: 2
  - sub-word store: 3
  - error: 1
- mem_address holds the word index for every state from LD/ST/RMW_RD through RESP. mem_read and mem_write are never high in the same cycle.
- Load formatting, little-endian:
  - Byte load selects lane addr[1:0].
  - Half load selects [15:0] or [31:16].
  - If req_signed, sign-extend from bit 7 or 15; otherwise zero-extend.
- resp_rdata holds its value until the next response. It is 0 for stores.
- mem_read_data is used only in cycles where mem_read=1; its value at other times is don't-care.
- Reset during RMW_RD leaves the memory word unmodified. Reset asserted in the RMW_WR cycle before the edge also aborts the write, because mem_write drops asynchronously.
- Back-to-back: a new request can be accepted in the cycle after RESP/ERR, since IDLE has req_ready=1.

Test Plan:
- Word store then load: sw 0xDEADBEEF to addr 0x10, then lw addr 0x10 → mem_address=4, mem_write for 1 cycle, resp at +2; load returns resp_rdata=0xDEADBEEF, resp_error=0.
- Sub-word store: preload word 4 = 0x11223344; sb 0xAA to addr 0x12 → mem_read then mem_write cycles, word becomes 0x11AA3344, resp at +3.
- Signed/unsigned byte loads: lb signed of addr 0x12 → 0xFFFFFFAA; lbu → 0x000000AA; lh signed of addr 0x12 → 0x000011AA.
- Errors: lw addr 0x13 → resp_error=1, resp_rdata=0 at +1, no mem_read/mem_write; sw to addr 0x400 (index 256) → error, memory unchanged; size=11 → error.
- Reset mid-RMW: assert rst_n low during RMW_RD of sh 0xBEEF to addr 0x10 → all outputs 0 immediately, word 4 unchanged, req_ready=1 after release.
- Handshake: hold req_valid high with 3 queued requests → req_ready low while busy, each request accepted exactly once, responses in order, no dropped or duplicated memory writes.
